// File: rtl/attack_scheduler.sv
// Attacker launch sequencer, dodge scorer and collision-to-game-over collapse for the dodge game.
// All outputs are registered and respond one clk_65M cycle after their input condition; there is no backpressure, and atk_landed is counted once per cycle.
// Define ATTK_SCHED_LEVEL_EN for level progression and the velocity ramp; without it, level is 0 and atk_yvel is ATTK_YVEL_DEF.
module attack_scheduler #(
  parameter int NUM_ATTK      = 5,
  parameter int SPAWN_GAP     = 60,
  parameter int ATTK_YVEL_DEF = 5,
  parameter int LEVEL_STEP    = 8,
  parameter int MAX_LEVEL     = 7
) (
  input  logic                clk_65M,
  input  logic                clear,
  input  logic                game_on,
  input  logic                game_stop,
  input  logic [16:0]         H_count,
  input  logic [16:0]         V_count,
  input  logic [NUM_ATTK-1:0] atk_landed,
  input  logic [NUM_ATTK-1:0] atk_hit,
  output logic [NUM_ATTK-1:0] atk_en,
  output logic [4:0]          atk_yvel,
  output logic [2:0]          level,
  output logic [15:0]         score,
  output logic                game_over
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAVE = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] OVER = 2'd3;

  localparam logic [7:0]          GAP_LAST = 8'(SPAWN_GAP - 1);
  localparam logic [2:0]          LAST_IDX = 3'(NUM_ATTK - 1);
  localparam logic [NUM_ATTK-1:0] EN_ONE   = {{(NUM_ATTK-1){1'b0}}, 1'b1};

  if (NUM_ATTK < 2 || NUM_ATTK > 8 || SPAWN_GAP < 1 || SPAWN_GAP > 255 ||
      LEVEL_STEP < 1 || LEVEL_STEP > 255 || MAX_LEVEL < 0 || MAX_LEVEL > 7 ||
      ATTK_YVEL_DEF < 0 || ATTK_YVEL_DEF + MAX_LEVEL > 31) begin : g_cfg_err
    $error("attack_scheduler: parameter out of range");
  end

  logic [1:0]          state;
  logic [7:0]          gap_cnt;
  logic [2:0]          idx;
  logic                ftick;
  logic                active;
  logic                hit_any;
  logic [NUM_ATTK-1:0] land_m;
  logic [3:0]          n_land;
  logic [16:0]         score_sum;
  logic [15:0]         score_nxt;

  assign ftick   = (H_count == 17'd0) && (V_count == 17'd0);
  assign active  = (state == WAVE) || (state == RUN);
  assign hit_any = |(atk_hit & atk_en);
  assign land_m  = atk_landed & atk_en;

  always_comb begin
    n_land = 4'd0;
    for (int i = 0; i < NUM_ATTK; i++) begin
      n_land = n_land + {3'd0, land_m[i]};
    end
  end

  assign score_sum = {1'b0, score} + {13'd0, n_land};
  assign score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // A hit in the same cycle as a landing wins: the landing is not scored.
  always_ff @(posedge clk_65M) begin
    if (clear || game_stop) begin
      state     <= IDLE;
      atk_en    <= '0;
      score     <= 16'd0;
      game_over <= 1'b0;
      gap_cnt   <= 8'd0;
      idx       <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (game_on) begin
            state  <= WAVE;
            atk_en <= EN_ONE;
          end
        end
        WAVE, RUN: begin
          if (hit_any) begin
            state     <= OVER;
            atk_en    <= '0;
            game_over <= 1'b1;
          end else begin
            score <= score_nxt;
            if (state == WAVE && ftick) begin
              if (gap_cnt == GAP_LAST) begin
                atk_en  <= atk_en | (EN_ONE << (idx + 3'd1));
                idx     <= idx + 3'd1;
                gap_cnt <= 8'd0;
                if ((idx + 3'd1) == LAST_IDX) state <= RUN;
              end else begin
                gap_cnt <= gap_cnt + 8'd1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ATTK_SCHED_LEVEL_EN
  localparam logic [2:0]  LVL_MAX = 3'(MAX_LEVEL);
  localparam logic [15:0] STEP    = 16'(LEVEL_STEP);

  logic [15:0] dodge_cnt;
  logic [15:0] dodge_sum;
  logic        lvl_up;
  logic [2:0]  level_nxt;

  assign dodge_sum = dodge_cnt + {12'd0, n_land};
  assign lvl_up    = dodge_sum >= STEP;

  always_comb begin
    level_nxt = level;
    if (lvl_up && level != LVL_MAX) level_nxt = level + 3'd1;
  end

  // Velocity is registered from the next level so both change on the same cycle.
  always_ff @(posedge clk_65M) begin
    if (clear || game_stop) begin
      dodge_cnt <= 16'd0;
      level     <= 3'd0;
      atk_yvel  <= 5'(ATTK_YVEL_DEF);
    end else if (active && !hit_any) begin
      dodge_cnt <= lvl_up ? (dodge_sum - STEP) : dodge_sum;
      level     <= level_nxt;
      atk_yvel  <= 5'(ATTK_YVEL_DEF) + {2'd0, level_nxt};
    end
  end
`else
  assign level    = 3'd0;
  assign atk_yvel = 5'(ATTK_YVEL_DEF);
`endif

endmodule

// File: tb/tb_attack_scheduler.sv
// Directed bench for attack_scheduler: a count-based game model checked every cycle plus literal spot checks.
module tb_attack_scheduler;

  localparam int NA   = 5;
  localparam int GAP  = 60;
  localparam int DEF  = 5;
  localparam int STEP = 8;
  localparam int MAXL = 7;
`ifdef ATTK_SCHED_LEVEL_EN
  localparam int L_AFTER8 = 1;
  localparam int L_SAT    = 7;
`else
  localparam int L_AFTER8 = 0;
  localparam int L_SAT    = 0;
`endif

  logic        clk_65M = 1'b0;
  logic        clear = 1'b0, game_on = 1'b0, game_stop = 1'b0;
  logic [16:0] H_count = 17'd1, V_count = 17'd1;
  logic [4:0]  atk_landed = 5'd0, atk_hit = 5'd0;
  logic [4:0]  atk_en;
  logic [4:0]  atk_yvel;
  logic [2:0]  level;
  logic [15:0] score;
  logic        game_over;

  attack_scheduler #(
    .NUM_ATTK(NA), .SPAWN_GAP(GAP), .ATTK_YVEL_DEF(DEF), .LEVEL_STEP(STEP), .MAX_LEVEL(MAXL)
  ) dut (
    .clk_65M(clk_65M), .clear(clear), .game_on(game_on), .game_stop(game_stop),
    .H_count(H_count), .V_count(V_count), .atk_landed(atk_landed), .atk_hit(atk_hit),
    .atk_en(atk_en), .atk_yvel(atk_yvel), .level(level), .score(score), .game_over(game_over)
  );

  always #5 clk_65M = ~clk_65M;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 launching, 2 all launched, 3 over; launches tracked as a count.
  int m_phase = 0, m_launched = 0, m_ticks = 0, m_score = 0, m_dodge = 0, m_lvl = 0;

  always @(posedge clk_65M) begin : model
    logic [4:0] enm;
    int n;
    enm = (m_phase == 1 || m_phase == 2) ? 5'((1 << m_launched) - 1) : 5'd0;
    if (clear || game_stop) begin
      m_phase = 0; m_launched = 0; m_ticks = 0; m_score = 0; m_dodge = 0; m_lvl = 0;
    end else if (m_phase == 0) begin
      if (game_on) begin
        m_phase = 1; m_launched = 1; m_ticks = 0;
      end
    end else if (m_phase != 3) begin
      if ((atk_hit & enm) != 5'd0) begin
        m_phase = 3;
      end else begin
        n = $countones(atk_landed & enm);
        m_score = (m_score + n > 65535) ? 65535 : m_score + n;
        m_dodge = m_dodge + n;
        if (m_dodge >= STEP) begin
          m_dodge = m_dodge - STEP;
          if (m_lvl < MAXL) m_lvl = m_lvl + 1;
        end
        if (m_phase == 1 && H_count == 17'd0 && V_count == 17'd0) begin
          m_ticks = m_ticks + 1;
          if (m_ticks == GAP) begin
            m_launched = m_launched + 1;
            m_ticks = 0;
            if (m_launched == NA) m_phase = 2;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // One clock, then compare every output against the model.
  task automatic cyc();
    logic [4:0] e_en;
    int e_lvl;
    @(posedge clk_65M);
    #1;
    if (chk_en) begin
      e_en  = (m_phase == 1 || m_phase == 2) ? 5'((1 << m_launched) - 1) : 5'd0;
`ifdef ATTK_SCHED_LEVEL_EN
      e_lvl = m_lvl;
`else
      e_lvl = 0;
`endif
      total++;
      if (atk_en !== e_en || atk_yvel !== 5'(DEF + e_lvl) || level !== 3'(e_lvl) ||
          score !== 16'(m_score) || game_over !== (m_phase == 3)) begin
        bad++;
        $display("FAIL model t=%0t got en=%b yvel=%0d lvl=%0d score=%0d over=%b want en=%b yvel=%0d lvl=%0d score=%0d over=%0d",
                 $time, atk_en, atk_yvel, level, score, game_over, e_en, DEF + e_lvl, e_lvl, m_score, m_phase == 3);
      end
    end
  endtask

  task automatic tick();
    H_count = 17'd0; V_count = 17'd0;
    cyc();
    H_count = 17'd1; V_count = 17'd1;
    cyc();
  endtask

  task automatic pulse_land(input logic [4:0] v);
    atk_landed = v;
    cyc();
    atk_landed = 5'd0;
  endtask

  initial begin
    clear = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_en", atk_en, 0);
    chk("rst_yvel", atk_yvel, DEF);
    chk("rst_level", level, 0);
    chk("rst_score", score, 0);
    chk("rst_over", game_over, 0);

    clear = 1'b0;
    game_on = 1'b1;
    cyc();
    chk("start_en", atk_en, 5'b00001);

    atk_hit = 5'b01000;
    cyc();
    atk_hit = 5'd0;
    chk("mask_hit_over", game_over, 0);
    chk("mask_hit_en", atk_en, 5'b00001);

    repeat (59) tick();
    chk("gap59_en", atk_en, 5'b00001);
    tick();
    chk("gap60_en", atk_en, 5'b00011);
    repeat (179) tick();
    chk("gap239_en", atk_en, 5'b01111);
    tick();
    chk("all_en", atk_en, 5'b11111);
    repeat (60) tick();
    chk("run_hold_en", atk_en, 5'b11111);

    repeat (8) begin
      pulse_land(5'b00001);
      cyc();
    end
    chk("score8", score, 8);
    chk("level8", level, L_AFTER8);
    chk("yvel8", atk_yvel, DEF + L_AFTER8);
    pulse_land(5'b11111);
    chk("score13", score, 13);
    chk("level13", level, L_AFTER8);

    atk_hit = 5'b00100;
    cyc();
    atk_hit = 5'd0;
    chk("hit_over", game_over, 1);
    chk("hit_en", atk_en, 0);
    pulse_land(5'b11111);
    chk("over_score", score, 13);
    cyc();

    game_stop = 1'b1;
    cyc();
    chk("stop_en", atk_en, 0);
    chk("stop_over", game_over, 0);
    chk("stop_score", score, 0);
    chk("stop_level", level, 0);
    chk("stop_yvel", atk_yvel, DEF);
    cyc();
    chk("stop_blocks_start", atk_en, 0);
    game_stop = 1'b0;
    cyc();
    chk("restart_en", atk_en, 5'b00001);

    atk_hit = 5'b00001;
    atk_landed = 5'b00001;
    cyc();
    atk_hit = 5'd0;
    atk_landed = 5'd0;
    chk("simul_over", game_over, 1);
    chk("simul_score", score, 0);

    game_stop = 1'b1;
    cyc();
    game_stop = 1'b0;
    cyc();
    repeat (240) tick();
    chk("run2_en", atk_en, 5'b11111);

    atk_landed = 5'b11111;
    repeat (13106) cyc();
    atk_landed = 5'b01111;
    cyc();
    chk("near_sat", score, 65534);
    atk_landed = 5'b00111;
    cyc();
    chk("sat_multi", score, 16'hFFFF);
    atk_landed = 5'b00001;
    cyc();
    atk_landed = 5'd0;
    chk("sat_hold", score, 16'hFFFF);
    chk("level_sat", level, L_SAT);
    chk("yvel_sat", atk_yvel, DEF + L_SAT);

    clear = 1'b1;
    cyc();
    chk("clr_en", atk_en, 0);
    chk("clr_score", score, 0);
    chk("clr_level", level, 0);
    clear = 1'b0;
    game_on = 1'b0;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
